led_pattern_gen: RTL and testbench

LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

---
 rtl/led_pkg.sv | 14 +
 rtl/led_prescaler.sv | 30 +++
 rtl/led_pattern_gen.sv | 162 ++++++++++++++++
 tb/tb_led_pattern_gen.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared definitions for the LED pattern generator: pattern mode encoding
// and the width of the step-period configuration field.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_BLINK   = 2'd1,
        MODE_CHASE   = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_t;

    localparam int PERIOD_W = 16;

endpackage

// File: rtl/led_prescaler.sv
// Tick prescaler: counts 0..TICK_DIV-1 while enabled and pulses tick on the wrap.
// A clear restarts the count from zero and suppresses the tick on that cycle.
module led_prescaler
    import led_pkg::*;
#(
    parameter int TICK_DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = en && !clr && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern generator: OFF / BLINK / CHASE / BREATHE driven by a tick-based step
// counter with a ready/valid period load. BREATHE needs macro LED_BREATHE_EN, else mode 3 is OFF.
module led_pattern_gen
    import led_pkg::*;
#(
    parameter int                  N_LED      = 4,
    parameter int                  TICK_DIV   = 50000,
    parameter int                  PWM_W      = 8,
    parameter logic [PERIOD_W-1:0] PERIOD_RST = 16'd100
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [1:0]          mode,
    input  logic                cfg_valid,
    input  logic [PERIOD_W-1:0] cfg_period,
    output logic                cfg_ready,
    output logic [N_LED-1:0]    led,
    output logic                step
);

    mode_t               mode_q;
    mode_t               mode_in;
    logic [PERIOD_W-1:0] period_q;
    logic [PERIOD_W-1:0] scnt_q;
    logic [PERIOD_W-1:0] pmax;
    logic                acc;
    logic                clr;
    logic                tick;
    logic                step_evt;

    assign mode_in  = mode_t'(mode);
    assign acc      = cfg_valid && cfg_ready;
    // Accept and mode change share one restart so both landing together restart once.
    assign clr      = acc || (mode_in != mode_q);
    assign pmax     = (period_q == '0) ? '0 : period_q - 1'b1;
    assign step_evt = tick && (scnt_q == pmax);

    led_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .clr  (clr),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q    <= MODE_OFF;
            period_q  <= PERIOD_RST;
            cfg_ready <= 1'b1;
            scnt_q    <= '0;
            step      <= 1'b0;
        end else begin
            mode_q    <= mode_in;
            cfg_ready <= !acc;
            step      <= step_evt;
            if (acc) begin
                period_q <= cfg_period;
            end
            if (clr) begin
                scnt_q <= '0;
            end else if (tick) begin
                scnt_q <= step_evt ? '0 : scnt_q + 1'b1;
            end
        end
    end

    logic             blink_q;
    logic             blink_n;
    logic [N_LED-1:0] chase_q;
    logic [N_LED-1:0] chase_n;
    logic [N_LED-1:0] breathe_led;
    logic [N_LED-1:0] led_n;

`ifdef LED_BREATHE_EN
    localparam logic [PWM_W-1:0] DUTY_MAX = {PWM_W{1'b1}};

    logic [PWM_W-1:0] duty_q;
    logic [PWM_W-1:0] duty_n;
    logic             up_q;
    logic             up_n;
    logic [PWM_W-1:0] pwm_q;
    logic [PWM_W-1:0] pwm_n;

    assign pwm_n = pwm_q + 1'b1;

    // Triangle ramp turns around at the extremes without repeating the end value.
    always_comb begin
        duty_n = duty_q;
        up_n   = up_q;
        if (clr) begin
            duty_n = '0;
            up_n   = 1'b1;
        end else if (step_evt) begin
            if (up_q) begin
                if (duty_q == DUTY_MAX) begin
                    duty_n = duty_q - 1'b1;
                    up_n   = 1'b0;
                end else begin
                    duty_n = duty_q + 1'b1;
                end
            end else begin
                if (duty_q == '0) begin
                    duty_n = duty_q + 1'b1;
                    up_n   = 1'b1;
                end else begin
                    duty_n = duty_q - 1'b1;
                end
            end
        end
    end

    assign breathe_led = {N_LED{pwm_n < duty_n}};

    always_ff @(posedge clk) begin
        if (rst) begin
            duty_q <= '0;
            up_q   <= 1'b1;
            pwm_q  <= '0;
        end else begin
            duty_q <= duty_n;
            up_q   <= up_n;
            pwm_q  <= pwm_n;
        end
    end
`else
    assign breathe_led = '0;
`endif

    // led is computed from next-state values so the register tracks mode_q and pattern state.
    always_comb begin
        blink_n = blink_q;
        chase_n = chase_q;
        if (clr) begin
            blink_n = 1'b0;
            chase_n = N_LED'(1);
        end else if (step_evt) begin
            blink_n = !blink_q;
            chase_n = {chase_q[N_LED-2:0], chase_q[N_LED-1]};
        end
        case (mode_in)
            MODE_BLINK:   led_n = {N_LED{blink_n}};
            MODE_CHASE:   led_n = chase_n;
            MODE_BREATHE: led_n = breathe_led;
            default:      led_n = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blink_q <= 1'b0;
            chase_q <= N_LED'(1);
            led     <= '0;
        end else begin
            blink_q <= blink_n;
            chase_q <= chase_n;
            led     <= led_n;
        end
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen: directed scenarios plus randomized traffic, all checked
// against an elapsed-time model of the pattern behaviour (honours LED_BREATHE_EN).
module tb_led_pattern_gen;

    localparam int N   = 4;
    localparam int TD  = 4;
    localparam int PW  = 3;
    localparam logic [15:0] PRST = 16'd2;
    localparam int ALL = (1 << N) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [1:0]    mode;
    logic          cfg_valid;
    logic [15:0]   cfg_period;
    logic          cfg_ready;
    logic [N-1:0]  led;
    logic          step;

    always #5 clk = ~clk;

    led_pattern_gen #(
        .N_LED      (N),
        .TICK_DIV   (TD),
        .PWM_W      (PW),
        .PERIOD_RST (PRST)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .mode       (mode),
        .cfg_valid  (cfg_valid),
        .cfg_period (cfg_period),
        .cfg_ready  (cfg_ready),
        .led        (led),
        .step       (step)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: active cycles since the last restart define the pattern.
    int m_mode   = 0;
    int m_period = int'(PRST);
    int m_act    = 0;
    int m_pwm    = 0;
    bit m_rdy    = 1'b1;
    bit m_step   = 1'b0;

    function automatic int clk_per_step();
        return TD * ((m_period == 0) ? 1 : m_period);
    endfunction

    function automatic int tri_duty(input int s);
        int mx;
        int k;
        mx = (1 << PW) - 1;
        k  = s % (2 * mx);
        return (k <= mx) ? k : 2 * mx - k;
    endfunction

    function automatic int exp_led();
        int s;
        s = m_act / clk_per_step();
        case (m_mode)
            1: return (s % 2 == 1) ? ALL : 0;
            2: return 1 << (s % N);
`ifdef LED_BREATHE_EN
            3: return (m_pwm < tri_duty(s)) ? ALL : 0;
`endif
            default: return 0;
        endcase
    endfunction

    always @(posedge clk) begin : model
        bit acc;
        bit restart;
        if (rst) begin
            m_mode   = 0;
            m_period = int'(PRST);
            m_act    = 0;
            m_pwm    = 0;
            m_rdy    = 1'b1;
            m_step   = 1'b0;
        end else begin
            acc     = cfg_valid && m_rdy;
            restart = acc || (int'(mode) != m_mode);
            if (acc) m_period = int'(cfg_period);
            m_rdy  = !acc;
            m_mode = int'(mode);
            m_pwm  = (m_pwm + 1) % (1 << PW);
            if (restart) begin
                m_act  = 0;
                m_step = 1'b0;
            end else if (en) begin
                m_act  = m_act + 1;
                m_step = (m_act % clk_per_step()) == 0;
            end else begin
                m_step = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick1();
        @(posedge clk);
        #1;
        chk("led", 32'(led), 32'(exp_led()));
        chk("step", 32'(step), 32'(m_step));
        chk("cfg_ready", 32'(cfg_ready), 32'(m_rdy));
    endtask

    task automatic wait_step(input int budget, output int c);
        c = 0;
        do begin
            tick1();
            c++;
        end while (!step && c < budget);
        if (!step) chk("step_timeout", 32'(0), 32'(1));
    endtask

    initial begin
        int c;
        int hi;
        int exp_d;
        logic [N-1:0] seq [4];
        seq = '{4'h2, 4'h4, 4'h8, 4'h1};

        rst = 1'b1; en = 1'b0; mode = 2'd0; cfg_valid = 1'b0; cfg_period = 16'd0;
        repeat (3) tick1();
        chk("rst_led", 32'(led), 32'(0));
        chk("rst_step", 32'(step), 32'(0));
        chk("rst_ready", 32'(cfg_ready), 32'(1));

        // Chase from reset with the reset period of 2 ticks.
        rst = 1'b0; mode = 2'd2; en = 1'b1;
        tick1();
        chk("chase_init", 32'(led), 32'(1));
        for (int i = 0; i < 4; i++) begin
            wait_step(40, c);
            chk("chase_gap", 32'(c), 32'(8));
            chk("chase_led", 32'(led), 32'(seq[i]));
        end

        // Blink with period 3 loaded together with the mode change, then freeze.
        mode = 2'd1; cfg_valid = 1'b1; cfg_period = 16'd3;
        tick1();
        chk("blink_acc_ready", 32'(cfg_ready), 32'(0));
        chk("blink_init", 32'(led), 32'(0));
        cfg_valid = 1'b0;
        tick1();
        chk("blink_ready_back", 32'(cfg_ready), 32'(1));
        wait_step(40, c);
        chk("blink_gap1", 32'(c), 32'(11));
        chk("blink_on", 32'(led), 32'(4'hF));
        wait_step(40, c);
        chk("blink_gap2", 32'(c), 32'(12));
        chk("blink_off", 32'(led), 32'(0));
        repeat (5) tick1();
        en = 1'b0;
        repeat (20) begin
            tick1();
            chk("freeze_led", 32'(led), 32'(0));
        end
        en = 1'b1;
        wait_step(40, c);
        chk("resume_gap", 32'(c), 32'(7));
        chk("resume_led", 32'(led), 32'(4'hF));

        // Period 5 load restarts chase.
        mode = 2'd2;
        tick1();
        cfg_valid = 1'b1; cfg_period = 16'd5;
        tick1();
        chk("p5_ready_low", 32'(cfg_ready), 32'(0));
        chk("p5_restart", 32'(led), 32'(1));
        cfg_valid = 1'b0;
        tick1();
        chk("p5_ready_high", 32'(cfg_ready), 32'(1));
        wait_step(60, c);
        chk("p5_gap", 32'(c + 1), 32'(20));
        chk("p5_led", 32'(led), 32'(2));

        // Period 0 acts as 1; reset mid-step and mid-handshake restores the reset period.
        cfg_valid = 1'b1; cfg_period = 16'd0;
        tick1();
        cfg_valid = 1'b0;
        wait_step(20, c);
        chk("p0_gap1", 32'(c), 32'(4));
        chk("p0_led1", 32'(led), 32'(2));
        wait_step(20, c);
        chk("p0_gap2", 32'(c), 32'(4));
        repeat (2) tick1();
        rst = 1'b1; cfg_valid = 1'b1; cfg_period = 16'd7;
        tick1();
        chk("mid_rst_led", 32'(led), 32'(0));
        chk("mid_rst_ready", 32'(cfg_ready), 32'(1));
        rst = 1'b0; cfg_valid = 1'b0;
        tick1();
        chk("post_rst_led", 32'(led), 32'(1));
        wait_step(40, c);
        chk("post_rst_gap", 32'(c), 32'(8));

        // Breathe: count lit cycles over each 8-cycle step to recover the duty.
        mode = 2'd3; cfg_valid = 1'b1; cfg_period = 16'd2;
        tick1();
        cfg_valid = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            wait_step(40, c);
            hi = int'(led[0]);
            repeat (7) begin
                tick1();
                hi += int'(led[0]);
            end
`ifdef LED_BREATHE_EN
            exp_d = tri_duty(k);
`else
            exp_d = 0;
`endif
            chk("breathe_duty", 32'(hi), 32'(exp_d));
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 99) < 6) mode = 2'($urandom_range(0, 3));
            en         = ($urandom_range(0, 9) != 0);
            cfg_valid  = ($urandom_range(0, 14) == 0);
            cfg_period = 16'($urandom_range(0, 3));
            rst        = ($urandom_range(0, 299) == 0);
            tick1();
        end
        rst = 1'b0;
        tick1();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
